// File: rtl/latch_arb_pkg.sv
// Shared opcodes and FSM states for the latch arbiter.
package latch_arb_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_SET   = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_CHECK
  } state_t;

endpackage

// File: rtl/latch_arbiter_if.sv
// Requester-side bundle of the latch arbiter.
interface latch_arbiter_if #(
  parameter int N    = 3,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [N*NREQ-1:0] wdata;
  logic [NREQ-1:0]   ack;
  logic [N-1:0]      rdata;
  logic              err;
  logic              busy;

  modport master (
    output req, op, wdata,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, op, wdata,
    output ack, rdata, err, busy
  );
endinterface

// File: rtl/latch_arbiter_rr_pick.sv
// Round-robin pick: first asserted req after last, wrapping at NREQ-1.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW-1:0] c;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    c     = last;
    for (int i = 0; i < NREQ; i++) begin
      c = (c == IW'(NREQ-1)) ? '0 : c + IW'(1);
      if (!valid && req[c]) begin
        valid    = 1'b1;
        idx      = c;
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_arbiter.sv
// Shares one gated latch among NREQ requesters with setup/pulse/hold sequencing.
module latch_arbiter
  import latch_arb_pkg::*;
#(
  parameter int N    = 3,
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  latch_arbiter_if.slave  bus,
  output logic            latch_gate,
  output logic            latch_aset,
  output logic            latch_aclr,
  output logic [N-1:0]    latch_data,
  input  logic [N-1:0]    latch_q
);

  localparam int IW = $clog2(NREQ);

  state_t          state, state_nx;
  logic            init_done;
  logic [IW-1:0]   last, win;
  logic [NREQ-1:0] win_oh;
  logic [1:0]      op_q;
  logic [N-1:0]    wd_q;
  logic [NREQ-1:0] ack_q;
  logic [N-1:0]    rdata_q;
  logic            err_q, busy_q;

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [1:0]      sel_op;
  logic [N-1:0]    sel_wd;
  logic [N-1:0]    expect_v;
  logic            mismatch;
  logic            grab;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .last  (last),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    sel_op = '0;
    sel_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_op = bus.op[2*i +: 2];
        sel_wd = bus.wdata[N*i +: N];
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_INIT:  state_nx = init_done ? ST_IDLE : ST_INIT;
      ST_IDLE:  if (pick_valid) state_nx = ST_SETUP;
      ST_SETUP: state_nx = ST_PULSE;
      ST_PULSE: state_nx = ST_HOLD;
      ST_HOLD:  state_nx = ST_CHECK;
      ST_CHECK: state_nx = ST_IDLE;
      default:  state_nx = ST_INIT;
    endcase
  end

  always_comb begin
    expect_v = wd_q;
    unique case (1'b1)
      (op_q == OP_SET):   expect_v = '1;
      (op_q == OP_CLEAR): expect_v = '0;
      default:            expect_v = wd_q;
    endcase
  end

  assign mismatch = (op_q != OP_READ) && (latch_q != expect_v);
  assign grab     = (state == ST_IDLE) && pick_valid;

  // Outputs are decoded from the next state so every latch pin is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      init_done  <= 1'b0;
      last       <= IW'(NREQ-1);
      win        <= '0;
      win_oh     <= '0;
      op_q       <= '0;
      wd_q       <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      latch_gate <= 1'b0;
      latch_aset <= 1'b0;
      latch_aclr <= 1'b0;
      latch_data <= '0;
    end else begin
      state      <= state_nx;
      busy_q     <= (state_nx != ST_IDLE);
      latch_gate <= (state_nx == ST_PULSE) && (op_q == OP_WRITE);
      latch_aset <= (state_nx == ST_PULSE) && (op_q == OP_SET);
      latch_aclr <= ((state == ST_INIT) && !init_done) ||
                    ((state_nx == ST_PULSE) && (op_q == OP_CLEAR));
      ack_q      <= (state_nx == ST_CHECK) ? win_oh : '0;
      err_q      <= (state_nx == ST_CHECK) && mismatch;
      if (state == ST_INIT)
        init_done <= 1'b1;
      if (grab) begin
        win        <= pick_idx;
        win_oh     <= pick_grant;
        op_q       <= sel_op;
        wd_q       <= sel_wd;
        latch_data <= sel_wd;
      end else if (state_nx == ST_IDLE || state_nx == ST_INIT) begin
        latch_data <= '0;
      end
      if (state_nx == ST_CHECK)
        rdata_q <= latch_q;
      if (state == ST_CHECK)
        last <= win;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_latch_arbiter.sv
// Directed and random checks of latch_arbiter against a behavioural latch and RR model.
module tb_latch_arbiter;

  localparam int N    = 3;
  localparam int NREQ = 4;

  logic         clk;
  logic         rst_n;
  logic         latch_gate, latch_aset, latch_aclr;
  logic [N-1:0] latch_data, latch_q, q_lat;
  logic         stuck_en;
  logic [N-1:0] stuck_val;

  int           tests;
  int           fails;
  int           last_m;
  logic [N-1:0] lat_m;

  latch_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  latch_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .latch_gate (latch_gate),
    .latch_aset (latch_aset),
    .latch_aclr (latch_aclr),
    .latch_data (latch_data),
    .latch_q    (latch_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_latch begin
    if (latch_aclr)      q_lat <= '0;
    else if (latch_aset) q_lat <= '1;
    else if (latch_gate) q_lat <= latch_data;
  end

  assign latch_q = stuck_en ? stuck_val : q_lat;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      assert (!(latch_aset && latch_aclr) &&
              !(latch_gate && (latch_aset || latch_aclr)) &&
              ($countones(bus.ack) <= 1)) else begin
        fails++;
        $error("FAIL exclusive: g=%b s=%b c=%b ack=%b required one-hot/none",
               latch_gate, latch_aset, latch_aclr, bus.ack);
      end
    end
  end

  task automatic set_req(input int i, input int o, input int d);
    bus.op[2*i +: 2]    = 2'(o);
    bus.wdata[N*i +: N] = N'(d);
    bus.req[i]          = 1'b1;
  endtask

  // Predict the winner from the current requests, wait for its ack, check all.
  task automatic serve(input string tag, input int lat);
    int           pred, n, g, s, c;
    logic [1:0]   eo;
    logic [N-1:0] ew, ex, er;
    logic         ee;
    bit           got;
    pred = -1;
    for (int i = 1; i <= NREQ; i++)
      if (pred < 0 && bus.req[(last_m + i) % NREQ])
        pred = (last_m + i) % NREQ;
    if (pred < 0) pred = 0;
    eo = bus.op[2*pred +: 2];
    ew = bus.wdata[N*pred +: N];
    n = 0; g = 0; s = 0; c = 0; got = 0;
    while (!got && n < 16) begin
      @(negedge clk);
      n++;
      if (latch_gate || latch_aset || latch_aclr)
        chk({tag, " pulse data"}, 32'(latch_data), 32'(ew));
      g += int'(latch_gate);
      s += int'(latch_aset);
      c += int'(latch_aclr);
      got = (bus.ack != '0);
    end
    case (eo)
      2'd0:    begin lat_m = ew; ex = ew; end
      2'd1:    begin lat_m = '1; ex = '1; end
      2'd2:    begin lat_m = '0; ex = '0; end
      default: ex = lat_m;
    endcase
    er = stuck_en ? stuck_val : lat_m;
    ee = (eo != 2'd3) && (er != ex);
    chk({tag, " ack"},     32'(bus.ack),   32'd1 << pred);
    chk({tag, " latency"}, 32'(n),         32'(lat));
    chk({tag, " rdata"},   32'(bus.rdata), 32'(er));
    chk({tag, " err"},     32'(bus.err),   32'(ee));
    chk({tag, " gates"},   32'(g),         32'(eo == 2'd0));
    chk({tag, " asets"},   32'(s),         32'(eo == 2'd1));
    chk({tag, " aclrs"},   32'(c),         32'(eo == 2'd2));
    last_m = pred;
  endtask

  initial begin
    int lat;
    tests = 0; fails = 0;
    last_m = NREQ - 1; lat_m = '0;
    rst_n = 1'b0; stuck_en = 1'b0; stuck_val = '0;
    bus.req = '0; bus.op = '0; bus.wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst ack",   32'(bus.ack),   0);
    chk("rst rdata", 32'(bus.rdata), 0);
    chk("rst err",   32'(bus.err),   0);
    chk("rst busy",  32'(bus.busy),  0);
    chk("rst pins",  32'({latch_gate, latch_aset, latch_aclr, latch_data}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init aclr", 32'(latch_aclr), 1);
    chk("init busy", 32'(bus.busy),   1);
    @(negedge clk);
    chk("idle aclr", 32'(latch_aclr), 0);
    chk("idle busy", 32'(bus.busy),   0);
    chk("idle q",    32'(latch_q),    0);
    chk("idle ack",  32'(bus.ack),    0);

    set_req(1, 0, 3'b110);
    serve("write1", 4);
    bus.req = '0;
    @(negedge clk);

    for (int i = 0; i < NREQ; i++) set_req(i, 0, i + 1);
    serve("rr", 4);
    repeat (4) serve("rr", 5);
    bus.req = '0;

    set_req(2, 1, 0);
    serve("set", 5);
    bus.req = '0;
    set_req(3, 2, 0);
    serve("clear", 5);
    bus.req = '0;

    stuck_en = 1'b1; stuck_val = 3'b010;
    set_req(0, 0, 3'b101);
    serve("stuck_w", 5);
    bus.req = '0;
    set_req(0, 3, 0);
    serve("stuck_r", 5);
    bus.req = '0;
    @(negedge clk);
    stuck_en = 1'b0;

    lat = 4;
    for (int t = 0; t < 40; t++) begin
      bus.req[last_m] = 1'b0;
      for (int i = 0; i < NREQ; i++)
        if (!bus.req[i] && $urandom_range(1, 0) == 1)
          set_req(i, int'($urandom_range(3, 0)), int'($urandom_range(7, 0)));
      if (bus.req == '0)
        set_req(int'($urandom_range(NREQ - 1, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(7, 0)));
      serve("rand", lat);
      lat = 5;
    end
    bus.req = '0;
    @(negedge clk);

    set_req(0, 0, 3);
    set_req(1, 0, 5);
    @(negedge clk);
    @(negedge clk);
    chk("abort gate", 32'(latch_gate), 1);
    rst_n = 1'b0;
    #1;
    chk("abort pins", 32'({latch_gate, latch_aset, latch_aclr, latch_data}), 0);
    chk("abort ack",  32'(bus.ack),  0);
    chk("abort busy", 32'(bus.busy), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort no ack", 32'(bus.ack), 0);
    end
    rst_n = 1'b1;
    last_m = NREQ - 1;
    lat_m = '0;
    @(negedge clk);
    chk("reinit aclr", 32'(latch_aclr), 1);
    serve("post_rst0", 5);
    bus.req[0] = 1'b0;
    serve("post_rst1", 5);
    bus.req = '0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
